axi_lite_dram_model: RTL

//  Parametrised AXI4-Lite slave memory model; successor to the fixed pseudo DRAM used by the Program benches.

---
 rtl/dram_model_pkg.sv | 41 ++++
 rtl/dram_lat_cnt.sv | 26 ++
 rtl/axi_lite_dram_model.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_model_pkg.sv
// Shared types and address decode for the AXI4-Lite DRAM model.
package dram_model_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_GOTA = 3'd1,
    WR_GOTW = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } wr_state_e;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } addr_chk_t;

  // Word index of a byte address, flagged when below base, past the end or misaligned.
  function automatic addr_chk_t addr_chk(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth,
                                         input logic [4:0]  offBits);
    addr_chk_t   res;
    logic [31:0] alignMask;
    alignMask = (32'd1 << offBits) - 32'd1;
    res.idx   = (addr - base) >> offBits;
    res.err   = (addr < base) || (res.idx >= depth) || ((addr & alignMask) != 32'd0);
    return res;
  endfunction

endpackage

// File: rtl/dram_lat_cnt.sv
// Loadable 8-bit down-counter used to time one channel's response latency.
module dram_lat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] loadVal,
  input  logic       en,
  output logic       done
);

  logic [7:0] cnt;

  // Load on a new transaction, otherwise count down to zero while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (en && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/axi_lite_dram_model.sv
// AXI4-Lite slave memory model with independent read and write channels.
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; valid held after that edge is ignored until ready returns high.
module axi_lite_dram_model
  import dram_model_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 2048,
  parameter int BASE_ADDR = 'h10000,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid,
  input  logic [ADDR_W-1:0]     ar_addr,
  output logic                  ar_ready,
  output logic                  r_valid,
  output logic [DATA_W-1:0]     r_data,
  output logic [1:0]            r_resp,
  input  logic                  r_ready,
  input  logic                  aw_valid,
  input  logic [ADDR_W-1:0]     aw_addr,
  output logic                  aw_ready,
  input  logic                  w_valid,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_strb,
  output logic                  w_ready,
  output logic                  b_valid,
  output logic [1:0]            b_resp,
  input  logic                  b_ready
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int OFF_BITS = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- read channel ----------------
  rd_state_e        rdState, rdNext;
  logic             rdLoad, rdSample, rdDone;
  addr_chk_t        arChk;
  logic             rdErrQ;
  logic [IDX_W-1:0] rdIdxQ;

  assign arChk    = addr_chk(32'(ar_addr), 32'(BASE_ADDR), 32'(DEPTH), 5'(OFF_BITS));
  assign ar_ready = rst_n && (rdState == RD_IDLE);
  assign r_valid  = (rdState == RD_RESP);

  dram_lat_cnt rdLatCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rdLoad),
    .loadVal (8'(RD_LAT - 1)),
    .en      (rdState == RD_WAIT),
    .done    (rdDone)
  );

  // Read next-state: accept, wait out the latency, then hold the response.
  always_comb begin
    rdNext   = rdState;
    rdLoad   = 1'b0;
    rdSample = 1'b0;
    case (rdState)
      RD_IDLE: if (ar_valid) begin
        rdLoad = 1'b1;
        rdNext = RD_WAIT;
      end
      RD_WAIT: if (rdDone) begin
        rdSample = 1'b1;
        rdNext   = RD_RESP;
      end
      RD_RESP: if (r_ready) rdNext = RD_IDLE;
      default: rdNext = RD_IDLE;
    endcase
  end

  // Read state, latched address and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdState <= RD_IDLE;
      rdErrQ  <= 1'b0;
      rdIdxQ  <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      rdState <= rdNext;
      if (rdLoad) begin
        rdErrQ <= arChk.err;
        rdIdxQ <= arChk.idx[IDX_W-1:0];
      end
      if (rdSample) begin
        r_data <= rdErrQ ? '0 : mem[rdIdxQ];
        r_resp <= rdErrQ ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e         wrState, wrNext;
  logic              wrLoad, wrCommit, wrDone, awHs, wHs;
  addr_chk_t         awChk;
  logic              awErrQ;
  logic [IDX_W-1:0]  awIdxQ;
  logic [DATA_W-1:0] wDataQ;
  logic [STRB_W-1:0] wStrbQ;

  assign awChk    = addr_chk(32'(aw_addr), 32'(BASE_ADDR), 32'(DEPTH), 5'(OFF_BITS));
  assign aw_ready = rst_n && ((wrState == WR_IDLE) || (wrState == WR_GOTW));
  assign w_ready  = rst_n && ((wrState == WR_IDLE) || (wrState == WR_GOTA));
  assign b_valid  = (wrState == WR_RESP);

  dram_lat_cnt wrLatCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wrLoad),
    .loadVal (8'(WR_LAT - 1)),
    .en      (wrState == WR_WAIT),
    .done    (wrDone)
  );

  // Write next-state: collect AW and W in any order, wait, commit, respond.
  always_comb begin
    wrNext   = wrState;
    wrLoad   = 1'b0;
    wrCommit = 1'b0;
    awHs     = 1'b0;
    wHs      = 1'b0;
    case (wrState)
      WR_IDLE: begin
        awHs = aw_valid;
        wHs  = w_valid;
        if (aw_valid && w_valid) begin
          wrLoad = 1'b1;
          wrNext = WR_WAIT;
        end else if (aw_valid) begin
          wrNext = WR_GOTA;
        end else if (w_valid) begin
          wrNext = WR_GOTW;
        end
      end
      WR_GOTA: begin
        wHs = w_valid;
        if (w_valid) begin
          wrLoad = 1'b1;
          wrNext = WR_WAIT;
        end
      end
      WR_GOTW: begin
        awHs = aw_valid;
        if (aw_valid) begin
          wrLoad = 1'b1;
          wrNext = WR_WAIT;
        end
      end
      WR_WAIT: if (wrDone) begin
        wrCommit = 1'b1;
        wrNext   = WR_RESP;
      end
      WR_RESP: if (b_ready) wrNext = WR_IDLE;
      default: wrNext = WR_IDLE;
    endcase
  end

  // Write state, captured address/data and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrState <= WR_IDLE;
      awErrQ  <= 1'b0;
      awIdxQ  <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
      b_resp  <= RESP_OKAY;
    end else begin
      wrState <= wrNext;
      if (awHs) begin
        awErrQ <= awChk.err;
        awIdxQ <= awChk.idx[IDX_W-1:0];
      end
      if (wHs) begin
        wDataQ <= w_data;
        wStrbQ <= w_strb;
      end
      if (wrCommit) b_resp <= awErrQ ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Byte-lane commit; the array has no reset so preloaded contents survive.
  // A read sampling the same word on this edge sees the old value.
  always_ff @(posedge clk) begin
    if (wrCommit && !awErrQ) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wStrbQ[b]) mem[awIdxQ][b*8 +: 8] <= wDataQ[b*8 +: 8];
      end
    end
  end

  // Index bits above the array size are already folded into the error flag.
  logic unusedIdxBits;
  assign unusedIdxBits = ^{arChk.idx[31:IDX_W], awChk.idx[31:IDX_W]};

endmodule
